// File: rtl/sram_seq.sv
// sram_seq: REQ/ACK sequencer driving one async 64Kx16 SRAM with registered CS/OE/WE strobes
module sram_seq #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ,
  input  logic          RW,
  input  logic [AW-1:0] ADDR_IN,
  input  logic [DW-1:0] WDATA,
  input  logic          WR_ALLOW,
  output logic          ACK,
  output logic          ERR,
  output logic          BUSY,
  output logic [DW-1:0] RDATA,
  output logic [AW-1:0] SRAM_ADDR,
  output logic [DW-1:0] SRAM_DQ_OUT,
  output logic          SRAM_DQ_OE,
  input  logic [DW-1:0] SRAM_DQ_IN,
  output logic          CS_BAR,
  output logic          OE_BAR,
  output logic          WE_BAR
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, REJECT} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d, rdata_q, rdata_d;
  logic cs_bar_q, cs_bar_d, oe_bar_q, oe_bar_d, we_bar_q, we_bar_d;
  logic dq_oe_q, dq_oe_d, ack_q, ack_d, err_q, err_d, busy_q, busy_d;
  logic strobe;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE:
        if (REQ) begin
          if (RW && !WR_ALLOW) state_d = REJECT;
          else begin
            state_d = SETUP;
            rw_d    = RW;
            addr_d  = ADDR_IN;
            dout_d  = WDATA;
          end
        end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = 4'(WAIT_CYC - 1);
      end
      ACCESS:
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          rdata_d = rw_q ? rdata_q : SRAM_DQ_IN;
        end else cnt_d = cnt_q - 4'd1;
      default: state_d = IDLE;
    endcase
    // outputs are registered, so they are decoded from the state being entered
    strobe   = (state_d == SETUP) || (state_d == ACCESS);
    cs_bar_d = !strobe;
    oe_bar_d = !(strobe && !rw_d);
    we_bar_d = !((state_d == ACCESS) && rw_d);
    dq_oe_d  = rw_d && (strobe || (state_d == HOLD));
    ack_d    = state_d == HOLD;
    err_d    = state_d == REJECT;
    busy_d   = state_d != IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      rdata_q  <= '0;
      cs_bar_q <= 1'b1;
      oe_bar_q <= 1'b1;
      we_bar_q <= 1'b1;
      dq_oe_q  <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      rdata_q  <= rdata_d;
      cs_bar_q <= cs_bar_d;
      oe_bar_q <= oe_bar_d;
      we_bar_q <= we_bar_d;
      dq_oe_q  <= dq_oe_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end
  assign ACK         = ack_q;
  assign ERR         = err_q;
  assign BUSY        = busy_q;
  assign RDATA       = rdata_q;
  assign SRAM_ADDR   = addr_q;
  assign SRAM_DQ_OUT = dout_q;
  assign SRAM_DQ_OE  = dq_oe_q;
  assign CS_BAR      = cs_bar_q;
  assign OE_BAR      = oe_bar_q;
  assign WE_BAR      = we_bar_q;
endmodule

// File: tb/tb_sram_seq.sv
// tb_sram_seq: scoreboard bench for sram_seq with a behavioural SRAM
module tb_sram_seq;
  localparam int WAIT = 2;
  logic CLK = 1'b0, RST = 1'b1, REQ = 1'b0, RW = 1'b0, WR_ALLOW = 1'b0;
  logic [15:0] ADDR_IN = '0, WDATA = '0, SRAM_DQ_IN, RDATA, SRAM_ADDR, SRAM_DQ_OUT;
  logic ACK, ERR, BUSY, SRAM_DQ_OE, CS_BAR, OE_BAR, WE_BAR;
  sram_seq #(.AW(16), .DW(16), .WAIT_CYC(WAIT)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .RW(RW), .ADDR_IN(ADDR_IN), .WDATA(WDATA),
    .WR_ALLOW(WR_ALLOW), .ACK(ACK), .ERR(ERR), .BUSY(BUSY), .RDATA(RDATA),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_OE(SRAM_DQ_OE),
    .SRAM_DQ_IN(SRAM_DQ_IN), .CS_BAR(CS_BAR), .OE_BAR(OE_BAR), .WE_BAR(WE_BAR)
  );
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  typedef struct {
    bit is_err; bit is_rd; logic [15:0] rdata; int at;
    int n_we; int n_oe; int n_cs; int n_dq;
  } exp_t;
  exp_t sb[$];
  logic [15:0] mem [0:65535];
  always @(posedge CLK) if (!CS_BAR && !WE_BAR && SRAM_DQ_OE) mem[SRAM_ADDR] <= SRAM_DQ_OUT;
  assign SRAM_DQ_IN = (!CS_BAR && !OE_BAR) ? mem[SRAM_ADDR] : 16'hDEAD;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  int n_we = 0, n_oe = 0, n_cs = 0, n_dq = 0;
  bit act_prev = 0;
  logic [15:0] a_h, d_h;
  always @(negedge CLK) begin
    exp_t e;
    chk("inv_dqoe_oe", {31'd0, SRAM_DQ_OE && !OE_BAR}, 0);
    chk("inv_we_cs_dq", {31'd0, !WE_BAR && (CS_BAR || !SRAM_DQ_OE)}, 0);
    chk("inv_oe_we", {31'd0, !OE_BAR && !WE_BAR}, 0);
    if (!CS_BAR || ACK) begin
      if (act_prev) begin
        chk("addr_stable", {16'd0, SRAM_ADDR}, {16'd0, a_h});
        chk("dout_stable", {16'd0, SRAM_DQ_OUT}, {16'd0, d_h});
      end else begin
        a_h = SRAM_ADDR;
        d_h = SRAM_DQ_OUT;
      end
      act_prev = 1;
    end else act_prev = 0;
    if (!WE_BAR) n_we++;
    if (!OE_BAR) n_oe++;
    if (!CS_BAR) n_cs++;
    if (SRAM_DQ_OE) n_dq++;
    if (ACK || ERR) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: ACK=%0b ERR=%0b required none (cycle %0d)", ACK, ERR, cyc);
      end else begin
        e = sb.pop_front();
        chk("err_pulse", {31'd0, ERR}, {31'd0, e.is_err});
        chk("ack_pulse", {31'd0, ACK}, {31'd0, !e.is_err});
        chk("latency", cyc, e.at);
        if (e.is_rd) chk("rdata", {16'd0, RDATA}, {16'd0, e.rdata});
        chk("we_low_cycles", n_we, e.n_we);
        chk("oe_low_cycles", n_oe, e.n_oe);
        chk("cs_low_cycles", n_cs, e.n_cs);
        chk("dq_oe_cycles", n_dq, e.n_dq);
      end
    end
    if (!BUSY) begin
      n_we = 0; n_oe = 0; n_cs = 0; n_dq = 0;
    end
  end
  task automatic txn(input bit rw, input logic [15:0] a, input logic [15:0] d, input bit allow,
                     input logic [15:0] exp_rd, input bit hold_req, output int done_cyc);
    exp_t e;
    bit ok;
    bit rej = rw && !allow;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (!BUSY) begin ok = 1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL idle_timeout: BUSY stuck at 1"); end
    REQ = 1; RW = rw; ADDR_IN = a; WDATA = d; WR_ALLOW = allow;
    e.is_err = rej;
    e.is_rd  = !rw;
    e.rdata  = exp_rd;
    e.at     = cyc + (rej ? 1 : WAIT + 2);
    e.n_we   = (rw && !rej) ? WAIT : 0;
    e.n_oe   = !rw ? WAIT + 1 : 0;
    e.n_cs   = rej ? 0 : WAIT + 1;
    e.n_dq   = (rw && !rej) ? WAIT + 2 : 0;
    sb.push_back(e);
    @(posedge CLK);
    #1 WR_ALLOW = !allow;
    ok = 0;
    done_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (ACK || ERR) begin ok = 1; done_cyc = cyc; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL done_timeout: no ACK/ERR within 50 cycles"); end
    if (!hold_req) REQ = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int c0, c1, c2, c3, c4;
    bit ok;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    RST = 1;
    repeat (2) @(negedge CLK);
    RST = 0;
    @(negedge CLK);
    chk("rst_cs", {31'd0, CS_BAR}, 1);
    chk("rst_oe", {31'd0, OE_BAR}, 1);
    chk("rst_we", {31'd0, WE_BAR}, 1);
    chk("rst_dqoe", {31'd0, SRAM_DQ_OE}, 0);
    chk("rst_ack_err_busy", {29'd0, ACK, ERR, BUSY}, 0);
    chk("rst_rdata", {16'd0, RDATA}, 0);
    chk("rst_addr", {16'd0, SRAM_ADDR}, 0);
    chk("rst_dout", {16'd0, SRAM_DQ_OUT}, 0);
    txn(1, 16'h1234, 16'hA5C3, 1, 16'h0000, 0, c0);
    chk("mem_written", {16'd0, mem[16'h1234]}, 32'hA5C3);
    txn(0, 16'h1234, 16'h0000, 1, 16'hA5C3, 0, c0);
    repeat (3) @(negedge CLK);
    chk("rdata_held", {16'd0, RDATA}, 32'hA5C3);
    txn(1, 16'h1234, 16'hFFFF, 0, 16'h0000, 0, c0);
    chk("reject_mem_kept", {16'd0, mem[16'h1234]}, 32'hA5C3);
    chk("reject_addr_kept", {16'd0, SRAM_ADDR}, 32'h1234);
    txn(0, 16'h1234, 16'h0000, 0, 16'hA5C3, 0, c0);
    txn(1, 16'h0BEE, 16'h5A5A, 1, 16'h0000, 0, c0);
    chk("rdata_held_over_write", {16'd0, RDATA}, 32'hA5C3);
    txn(1, 16'h0000, 16'h1111, 1, 16'h0000, 1, c0);
    txn(0, 16'h0000, 16'h0000, 1, 16'h1111, 1, c1);
    chk("spacing_1", c1 - c0, 5);
    txn(1, 16'hFFFF, 16'hEEEE, 1, 16'h0000, 1, c2);
    chk("spacing_2", c2 - c1, 5);
    txn(0, 16'hFFFF, 16'h0000, 1, 16'hEEEE, 1, c3);
    chk("spacing_3", c3 - c2, 5);
    txn(0, 16'h0000, 16'h0000, 0, 16'h1111, 0, c4);
    chk("spacing_4", c4 - c3, 5);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (!BUSY) begin ok = 1; break; end
    end
    chk("pre_reset_idle", {31'd0, ok}, 1);
    REQ = 1; RW = 1; ADDR_IN = 16'h0042; WDATA = 16'h7777; WR_ALLOW = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (!WE_BAR) begin ok = 1; break; end
    end
    chk("reset_reached_access", {31'd0, ok}, 1);
    RST = 1;
    REQ = 0;
    @(negedge CLK);
    chk("abort_strobes", {29'd0, CS_BAR, OE_BAR, WE_BAR}, 32'h7);
    chk("abort_dqoe", {31'd0, SRAM_DQ_OE}, 0);
    chk("abort_ack_busy", {30'd0, ACK, BUSY}, 0);
    RST = 0;
    repeat (4) @(negedge CLK);
    txn(0, 16'h1234, 16'h0000, 1, 16'hA5C3, 0, c0);
    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_seq.md
Name: sram_seq

Overview:
- Cycle-accurate access sequencer for one 71V016-class asynchronous SRAM (64K x 16, BHE/BLE tied low on the board).
- Accepts single-word read/write requests from the tester core over a REQ/ACK handshake.
- Drives the SRAM address, data-bus drive enable and the active-low CS/OE/WE strobes with guaranteed setup/hold spacing.
- Writes are permitted only while the tester is in vector-apply mode; all other writes are rejected.

Parameters:
- AW, 16, SRAM address width.
- DW, 16, SRAM data width.
- WAIT_CYC, 2, clock cycles in the ACCESS phase (strobe-active width); legal range 1..15.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous reset, active high.
- REQ  input  1  request valid; sampled only in IDLE.
- RW  input  1  1 = write, 0 = read; sampled with REQ.
- ADDR_IN  input  AW  request address; sampled with REQ.
- WDATA  input  DW  write data; sampled with REQ.
- WR_ALLOW  input  1  1 = vector-apply mode, writes permitted; sampled with REQ.
- ACK  output  1  one-cycle pulse: transaction complete; RDATA valid for reads.
- ERR  output  1  one-cycle pulse: write rejected because WR_ALLOW=0.
- BUSY  output  1  high in every state except IDLE.
- RDATA  output  DW  last read data; held until the next read completes.
- SRAM_ADDR  output  AW  SRAM address pins (registered).
- SRAM_DQ_OUT  output  DW  data to pad tristate.
- SRAM_DQ_OE  output  1  1 = FPGA drives the DQ bus.
- SRAM_DQ_IN  input  DW  data from pad.
- CS_BAR  output  1  chip select, active low.
- OE_BAR  output  1  output enable, active low.
- WE_BAR  output  1  write enable, active low.

Behaviour:
- Reset (RST=1 at an edge) forces the following on the next cycle: state=IDLE, CS_BAR=OE_BAR=WE_BAR=1, SRAM_DQ_OE=0, ACK=ERR=BUSY=0, RDATA=0, SRAM_ADDR=0, SRAM_DQ_OUT=0.
- Reset mid-transaction aborts the transaction: no ACK, and strobes go inactive the next cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, SETUP, ACCESS, HOLD, REJECT.
- IDLE:
  - REQ=0: remain in IDLE.
  - REQ=1, RW=1, WR_ALLOW=0: go to REJECT. No SRAM pin changes.
  - Any other REQ=1: latch ADDR_IN into SRAM_ADDR, WDATA into SRAM_DQ_OUT, and latch RW; go to SETUP.
- REJECT: ERR=1 for exactly this cycle; go to IDLE.
- SETUP (1 cycle): CS_BAR=0.
  - Write: SRAM_DQ_OE=1, WE_BAR=1, OE_BAR=1.
  - Read: OE_BAR=0, SRAM_DQ_OE=0.
  - Go to ACCESS.
- ACCESS (exactly WAIT_CYC cycles, counted by an internal down-counter):
  - Write: WE_BAR=0 throughout.
  - Read: OE_BAR=0 throughout; on the edge leaving the last ACCESS cycle, capture SRAM_DQ_IN into RDATA.
  - Go to HOLD.
- HOLD (1 cycle): WE_BAR=1, OE_BAR=1, CS_BAR=1, ACK=1.
  - Write: SRAM_DQ_OE stays 1 for data hold.
  - SRAM_ADDR is unchanged.
  - Go to IDLE; SRAM_DQ_OE=0 in IDLE.
- Latency: REQ accepted at edge k; ACK is high in cycle k+WAIT_CYC+2. Minimum back-to-back spacing is WAIT_CYC+3 cycles, because the IDLE cycle is mandatory.
- REQ asserted while BUSY=1 is ignored. It is not queued; the requester must hold REQ until ACK or ERR.
- Invariants, checked every cycle:
  - SRAM_DQ_OE=1 implies OE_BAR=1 (no bus contention).
  - WE_BAR=0 implies CS_BAR=0 and SRAM_DQ_OE=1.
  - OE_BAR and WE_BAR are never both 0.
  - SRAM_ADDR and SRAM_DQ_OUT are stable from SETUP through HOLD.
- WR_ALLOW changing after acceptance has no effect on the in-flight transaction.
- Reads are allowed regardless of WR_ALLOW.
- Address 0xFFFF and address 0 are ordinary addresses; the block does no address arithmetic.

Test Plan:
1. Reset then idle: RST=1 for 2 cycles, then 0 -> CS_BAR=OE_BAR=WE_BAR=1, SRAM_DQ_OE=0, ACK=ERR=BUSY=0, RDATA=0.
2. Write 0xA5C3 to address 0x1234 with WR_ALLOW=1, WAIT_CYC=2 -> SETUP then WE_BAR low for exactly 2 cycles; DQ_OUT=0xA5C3 and ADDR=0x1234 are stable through HOLD; ACK in cycle k+4; no cycle with OE_BAR=0.
3. Read address 0x1234 with the SRAM model returning 0xA5C3 -> OE_BAR low for 3 cycles (SETUP plus 2 ACCESS), SRAM_DQ_OE=0 throughout, ACK at k+4, RDATA=0xA5C3 and held afterwards.
4. Write with WR_ALLOW=0 -> ERR pulses one cycle at k+1, no ACK, CS_BAR and WE_BAR stay 1, SRAM memory contents unchanged.
5. REQ held continuously over alternating write/read at 0x0000 and 0xFFFF -> each transaction separated by one IDLE cycle, spacing 5 cycles, data read back matches data written.
6. RST asserted during ACCESS of a write -> next cycle all strobes are 1 and SRAM_DQ_OE=0, no ACK; a following read completes normally.
